// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the request fields captured at acceptance.
package dmem_pkg;

  // Captured addresses are widened to this so the range check works for any ADDR_WIDTH up to 64.
  localparam int REQ_ADDR_W = 64;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [1:0]            size;
    logic                  is_unsigned;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into the addressed word and extracts
// and extends load data; also flags half/word misalignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = old_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    store_word = old_word;
    load_value = '0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        load_value = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        load_value = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign   = (addr_lo != 2'b00);
        store_word = wdata;
        load_value = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with configurable
// wait states, an internal word array and a registered response channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DAT_WIDTH-1:0]  req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DAT_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e               state, state_next;
  logic [CNT_W-1:0]     cnt;
  req_t                 cap;
  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic             out_of_range;
  logic             misalign;
  logic             access_err;
  logic             do_access;
  logic [31:0]      old_word;
  logic [31:0]      store_word;
  logic [31:0]      load_value;

  assign word_idx     = cap.addr[IDX_W+1:2];
  assign out_of_range = cap.addr[REQ_ADDR_W-1:2] >= (REQ_ADDR_W-2)'(DEPTH);
  assign old_word     = mem[word_idx];
  assign access_err   = (cap.size == SZ_ILLEGAL) || misalign || out_of_range;
  assign do_access    = (state == WAIT) && (cnt == '0);

  dmem_lane_align u_lane_align (
    .old_word    (old_word),
    .addr_lo     (cap.addr[1:0]),
    .size        (cap.size),
    .is_unsigned (cap.is_unsigned),
    .wdata       (cap.wdata),
    .store_word  (store_word),
    .load_value  (load_value),
    .misalign    (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)      state_next = WAIT;
      WAIT:    if (cnt == '0)      state_next = RESP;
      RESP:    if (resp_ready)     state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  // Request capture, wait-state countdown and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      cap        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap.write       <= req_write;
            cap.addr        <= REQ_ADDR_W'(req_addr);
            cap.wdata       <= req_wdata;
            cap.size        <= req_size;
            cap.is_unsigned <= req_unsigned;
            cnt             <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_err   <= access_err;
            resp_rdata <= (access_err || cap.write) ? '0 : load_value;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never reset; a reset landing on the access edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && cap.write && !access_err)
      mem[word_idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance exercised with
// handshakes, backpressure and reset, plus a WAIT_CYCLES=0 back-to-back instance.
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int PERIOD = 10;
  localparam int LAT_A  = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_s;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_z, req_ready_z, req_write_z, req_unsigned_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [1:0]  req_size_z;
  logic        resp_valid_z, resp_err_z, busy_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_a [int unsigned];
  logic [31:0] model_z [int unsigned];
  exp_t        sb_a[$];
  exp_t        sb_z[$];

  always #(PERIOD/2) clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_size(req_size_z),
    .req_unsigned(req_unsigned_z),
    .resp_valid(resp_valid_z), .resp_ready(1'b1), .resp_rdata(resp_rdata_z),
    .resp_err(resp_err_z), .busy(busy_z)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference behaviour: error rules, lane merge and sign/zero extension.
  task automatic modelAccess(input logic [31:0] old_word, input req_s r,
                             output logic [31:0] new_word, output exp_t e);
    logic        err;
    logic [7:0]  b;
    logic [15:0] h;
    err = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
          (r.size == 2'd2 && r.addr[1:0] != 2'b00) || (r.addr[31:2] >= DEPTH);
    new_word = old_word;
    e.rdata  = 32'h0;
    e.err    = err;
    b = 8'h0;
    h = 16'h0;
    if (!err) begin
      if (r.write) begin
        case (r.size)
          2'd0: case (r.addr[1:0])
                  2'd0: new_word[7:0]   = r.wdata[7:0];
                  2'd1: new_word[15:8]  = r.wdata[7:0];
                  2'd2: new_word[23:16] = r.wdata[7:0];
                  default: new_word[31:24] = r.wdata[7:0];
                endcase
          2'd1: if (r.addr[1]) new_word[31:16] = r.wdata[15:0];
                else           new_word[15:0]  = r.wdata[15:0];
          default: new_word = r.wdata;
        endcase
      end else begin
        case (r.size)
          2'd0: begin
            case (r.addr[1:0])
              2'd0: b = old_word[7:0];
              2'd1: b = old_word[15:8];
              2'd2: b = old_word[23:16];
              default: b = old_word[31:24];
            endcase
            e.rdata = r.uns ? {24'h0, b} : {{24{b[7]}}, b};
          end
          2'd1: begin
            h = r.addr[1] ? old_word[31:16] : old_word[15:0];
            e.rdata = r.uns ? {16'h0, h} : {{16{h[15]}}, h};
          end
          default: e.rdata = old_word;
        endcase
      end
    end
  endtask

  task automatic pushExpected(input bit which_z, input req_s r);
    logic [31:0]  old_word, new_word;
    exp_t         e;
    int unsigned  idx;
    idx = r.addr[31:2];
    if (which_z) old_word = model_z.exists(idx) ? model_z[idx] : 32'h0;
    else         old_word = model_a.exists(idx) ? model_a[idx] : 32'h0;
    modelAccess(old_word, r, new_word, e);
    if (r.write && !e.err) begin
      if (which_z) model_z[idx] = new_word;
      else         model_a[idx] = new_word;
    end
    if (which_z) sb_z.push_back(e);
    else         sb_a.push_back(e);
  endtask

  // Drives one request into the main instance and returns after its acceptance edge.
  task automatic applyStimulus(input string tag, input req_s r, input bit track);
    int n;
    @(negedge clk);
    req_write    = r.write;
    req_addr     = r.addr;
    req_wdata    = r.wdata;
    req_size     = r.size;
    req_unsigned = r.uns;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    if (track) pushExpected(1'b0, r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collectResponse(input string tag, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT_A));
    if (sb_a.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_a.pop_front();
    checkOutput({tag, "_rdata"}, resp_rdata, e.rdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      checkOutput({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_post_rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic doTxn(input string tag, input logic write, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input int hold);
    req_s r;
    r = '{write: write, addr: addr, wdata: wdata, size: size, uns: uns};
    applyStimulus(tag, r, 1'b1);
    collectResponse(tag, hold);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_s zreqs[4];
    req_s r;
    exp_t e;
    time  t_acc, t_prev;
    int   n;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    req_size_z = 2'd0; req_unsigned_z = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);

    doTxn("st_word_10",  1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0);
    doTxn("ld_word_10",  1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0);

    doTxn("st_word_20",  1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 0);
    doTxn("st_byte_22",  1'b1, 32'h22, 32'h000000AA, 2'd0, 1'b0, 0);
    doTxn("ld_word_20",  1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 0);
    doTxn("ld_sbyte_22", 1'b0, 32'h22, 32'h0,        2'd0, 1'b0, 0);
    doTxn("ld_ubyte_22", 1'b0, 32'h22, 32'h0,        2'd0, 1'b1, 0);

    doTxn("st_word_30",  1'b1, 32'h30, 32'hCAFEBABE, 2'd2, 1'b0, 0);
    doTxn("st_half_32",  1'b1, 32'h32, 32'h00008001, 2'd1, 1'b0, 0);
    doTxn("ld_shalf_32", 1'b0, 32'h32, 32'h0,        2'd1, 1'b0, 0);
    doTxn("ld_uhalf_32", 1'b0, 32'h32, 32'h0,        2'd1, 1'b1, 0);
    doTxn("ld_word_30",  1'b0, 32'h30, 32'h0,        2'd2, 1'b0, 0);

    doTxn("st_word_40",  1'b1, 32'h40,   32'h0BADF00D, 2'd2, 1'b0, 0);
    doTxn("err_ld_h31",  1'b0, 32'h31,   32'h0,        2'd1, 1'b0, 0);
    doTxn("err_st_w42",  1'b1, 32'h42,   32'hFFFFFFFF, 2'd2, 1'b0, 0);
    doTxn("err_size3",   1'b1, 32'h40,   32'hFFFFFFFF, 2'd3, 1'b0, 0);
    doTxn("err_st_oor",  1'b1, 32'h1000, 32'hFFFFFFFF, 2'd2, 1'b0, 0);
    doTxn("err_ld_oor",  1'b0, 32'h1000, 32'h0,        2'd2, 1'b0, 0);
    doTxn("ld_word_40",  1'b0, 32'h40,   32'h0,        2'd2, 1'b0, 0);
    doTxn("ld_top_word", 1'b0, 32'h0FFC, 32'h0,        2'd2, 1'b0, 0);

    doTxn("bp_ld_10",    1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);

    // Store aborted by reset while in WAIT must leave 0x50 untouched.
    doTxn("st_word_50",  1'b1, 32'h50, 32'h12345678, 2'd2, 1'b0, 0);
    r = '{write: 1'b1, addr: 32'h50, wdata: 32'hFFFFFFFF, size: 2'd2, uns: 1'b0};
    applyStimulus("abort_st_50", r, 1'b0);
    checkOutput("abort_busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rdata", resp_rdata, 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
    doTxn("ld_word_50",  1'b0, 32'h50, 32'h0, 2'd2, 1'b0, 0);

    // Zero-wait instance, request held valid continuously, response always accepted.
    zreqs[0] = '{write: 1'b1, addr: 32'h100, wdata: 32'hA5A50F0F, size: 2'd2, uns: 1'b0};
    zreqs[1] = '{write: 1'b0, addr: 32'h100, wdata: 32'h0,        size: 2'd2, uns: 1'b0};
    zreqs[2] = '{write: 1'b1, addr: 32'h101, wdata: 32'h0000005A, size: 2'd0, uns: 1'b0};
    zreqs[3] = '{write: 1'b0, addr: 32'h100, wdata: 32'h0,        size: 2'd1, uns: 1'b1};
    t_prev = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_write_z    = zreqs[i].write;
      req_addr_z     = zreqs[i].addr;
      req_wdata_z    = zreqs[i].wdata;
      req_size_z     = zreqs[i].size;
      req_unsigned_z = zreqs[i].uns;
      req_valid_z    = 1'b1;
      n = 0;
      while (!req_ready_z && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready_z) checkOutput("z_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      t_acc = $time;
      pushExpected(1'b1, zreqs[i]);
      if (i > 0) checkOutput("z_spacing", 32'((t_acc - t_prev) / PERIOD), 32'd3);
      t_prev = t_acc;
      @(negedge clk);
      checkOutput("z_valid_early", 32'(resp_valid_z), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("z_valid", 32'(resp_valid_z), 32'd1);
      e = sb_z.pop_front();
      checkOutput("z_rdata", resp_rdata_z, e.rdata);
      checkOutput("z_err", 32'(resp_err_z), 32'(e.err));
    end
    req_valid_z = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("z_idle_busy", 32'(busy_z), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store request interface driven by the CPU memory stage.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word reads and writes on an internal word array.
- Returns registered read data and an error flag over a valid/ready response channel.
- Sits between the pipeline's memory stage (or a future stall-capable bus adapter) and data storage.

Parameters:
ADDR_WIDTH, 32, byte-address width
DAT_WIDTH, 32, data width (fixed 32 for lane logic)
DEPTH, 1024, number of 32-bit words; legal word index 0..DEPTH-1
WAIT_CYCLES, 2, extra wait states between acceptance and access (0 allowed)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DAT_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  DAT_WIDTH  load result (0 for stores and errors)
resp_err  output  1  misaligned, out-of-range or illegal-size request
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <- IDLE.
  - resp_valid, resp_rdata, resp_err, busy <- 0; req_ready = 1 after reset.
  - Wait counter <- 0.
  - Memory array contents are not cleared and are preserved across reset.
  - rst overrides every other input in the same cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture write/addr/wdata/size/unsigned, load counter with WAIT_CYCLES, go to WAIT.
  - WAIT: req_ready=0. If counter != 0, decrement. If counter == 0, perform the access at this edge, register resp_rdata/resp_err, go to RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs are held stable while resp_ready=0. On resp_ready=1, go to IDLE and clear resp_valid, resp_rdata and resp_err.
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+WAIT_CYCLES+1.
- Throughput: one outstanding request. A new request is accepted no earlier than the cycle after the response handshake, so minimum spacing is WAIT_CYCLES+3 cycles.
- Error detection, evaluated on captured fields:
  - size==3
  - size==1 with addr[0]=1
  - size==2 with addr[1:0]!=0
  - word index addr[ADDR_WIDTH-1:2] >= DEPTH
  - On error: no memory write, resp_rdata=0, resp_err=1.
- Stores:
  - Merge into the addressed word by lane.
  - Byte: lane addr[1:0] <- wdata[7:0].
  - Half: lanes addr[1]*2 +: 2 <- wdata[15:0].
  - Word: full write.
  - Untouched lanes keep their value. resp_rdata=0.
- Loads:
  - Extract the lane selected by addr[1:0] (byte) or addr[1] (half).
  - Sign- or zero-extend to 32 bits per req_unsigned; req_unsigned is ignored for word.
- Read-after-write: a load accepted after a store's response handshake returns the stored data. No bypass is needed since requests are serialized.
- req_valid in WAIT/RESP is ignored; the requester must hold it until req_ready.
- Reset during WAIT discards the pending access (no write). Reset during RESP drops the response.

Decomposition:
- Package dmem_pkg:
  - size enum SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - state enum IDLE/WAIT/RESP
  - captured-request struct (write, addr, wdata, size, unsigned)
- Sub-module dmem_lane_align, combinational:
  - inputs: old word, addr[1:0], size, unsigned, wdata
  - outputs: merged store word, extended load value, misalign flag
- dmem_responder holds the FSM, counter, array and output registers.

Test Plan:
- Word store then load, WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF, then load word 0x10 -> resp_rdata=0xDEADBEEF, err=0, resp_valid exactly 3 cycles after each acceptance edge.
- Byte lanes: word 0x20=0x11223344; store byte 0xAA at 0x22 -> word reads 0x11AA3344. Load signed byte 0x22 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half: store half 0x8001 at 0x32; signed load half 0x32 -> 0xFFFF8001; unsigned -> 0x00008001; word 0x30 low half unchanged.
- Errors: half load 0x31, word store 0x42, size=3, addr 4*DEPTH -> resp_err=1, rdata=0, and a subsequent word load of 0x40 shows no corruption.
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0. Assert rst during WAIT of a store to 0x50 (prior 0x12345678) -> after reset req_ready=1, resp_valid=0, and a load of 0x50 returns 0x12345678.
- WAIT_CYCLES=0 build: back-to-back requests with resp_ready tied 1 -> resp_valid one cycle after acceptance, new acceptance every 3 cycles.
